sm83_adr_seq: RTL and testbench
===============================

# sm83_adr_seq

M-cycle sequencer for the SM83 address latch/incrementer datapath. Accepts one address request per machine cycle from the instruction decoder and walks a four-T-state M-cycle (T1..T4). It drives the latch-write, high-byte-FF, inc/dec, carry-in and increment-output-enable controls of the address unit, together with the memory read/write strobes and the register-file write-back strobe. Memory wait states are inserted by holding T2.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  decoder presents a request.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_kind  in  3  0 BUS, 1 INC, 2 DEC, 3 HIFF, 4 KEEP_INC, 5 KEEP; 6/7 are treated as KEEP.
- req_dir  in  2  00 none (internal cycle), 01 read, 10 write; 11 is treated as none.
- mem_wait  in  1  memory not ready; sampled in T2 only.
- ctl_al_we  out  1  address latch write enable.
- ctl_al_hi_ff  out  1  force high byte to 0xFF on latch write.
- ctl_inc_dec  out  1  incrementer decrements.
- ctl_inc_cy  out  1  incrementer carry-in.
- ctl_inc_oe  out  1  latch loads from incrementer.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- wb_we  out  1  register file stores the post-inc/dec address.
- done  out  1  one-cycle pulse in T4.
- busy  out  1  state is not IDLE.
- mcycle_cnt  out  8  completed M-cycles, wraps 0xFF->0x00.

## Operation
- States: IDLE, T1, T2, T3, T4. Encoding is free.
- Accept = req_valid && req_ready. req_ready = (state==IDLE) || (state==T4).
- On accept, kind and dir are latched. All ctl/mem/wb outputs are a function of the registered state and the latched fields only. There is no combinational path from req_* to any ctl_* output.
- Transitions:
  - IDLE->T1 on accept, else stay IDLE.
  - T1->T2.
  - T2->T2 while mem_wait && dir in {read, write}, else T2->T3.
  - T3->T4.
  - T4->T1 on accept, else T4->IDLE.
- T1 drives:
  - ctl_al_we=1 for BUS, INC, DEC, HIFF.
  - ctl_al_hi_ff=1 for HIFF.
  - ctl_inc_oe=0.
  - KEEP and KEEP_INC do not write the latch in T1.
- T3 drives, for INC, DEC and KEEP_INC:
  - ctl_al_we=1, ctl_inc_oe=1, ctl_inc_cy=1.
  - ctl_inc_dec=1 for DEC only.
- T4: wb_we=1 for INC, DEC and KEEP_INC.
- ctl_al_hi_ff and ctl_inc_oe are never high together.
- ctl_inc_cy is 0 outside T3.
- mem_rd (read) or mem_wr (write) is high in T1, all T2 cycles, and T3; low in T4. Both stay 0 for dir none.
- done=1 in T4. mcycle_cnt increments in T4, modulo 256.

## Timing
- Reset value of every output: 0, except req_ready=1 (state IDLE). mcycle_cnt=0x00. Latched kind=BUS, latched dir=none.
- Reset asserted in any state, including mid-stall: next cycle is IDLE with all strobes 0. No done, no wb_we, and the in-flight request is dropped.
- Unstalled latency:
  - Accept in IDLE -> T1 next cycle -> done 4 cycles after accept.
  - Back-to-back accepts in T4 give one M-cycle every 4 clocks with no IDLE gap.
- Each wait cycle adds exactly one T2. mem_wait is ignored in T1, T3, T4 and for dir none.
- req_valid high in T1..T3 is not accepted and must be held by the decoder.
- The address unit latches on the falling clock edge. All outputs are stable for the full clock period of their state.

## Test plan
- INC read: reset, then accept kind=1 dir=01 in IDLE, no wait. Required response:
  - T1: ctl_al_we=1.
  - T3: al_we/inc_oe/cy=1, dec=0.
  - T4: wb_we=1, done=1.
  - mem_rd high for exactly 3 cycles; mcycle_cnt=1.
- DEC write with 2 wait cycles: mem_wait=1 for the first two T2 cycles. Required response:
  - T2 lasts 3 cycles and mem_wr is high for 5 cycles.
  - T3 has ctl_inc_dec=1.
  - done arrives 6 cycles after accept.
- HIFF read then KEEP_INC dir none, back-to-back in T4. Required response:
  - Second T1 follows T4 directly.
  - First T1: hi_ff=1, al_we=1.
  - Second M-cycle: no al_we in T1, al_we+inc_oe in T3, mem_rd/mem_wr=0.
- mem_wait=1 during a dir=none KEEP M-cycle -> no stall, done 4 cycles after accept, and no ctl output is ever asserted.
- Reset pulsed during the second stalled T2 of a write. Required response:
  - Next cycle: IDLE, mem_wr=0, req_ready=1, mcycle_cnt=0.
  - No wb_we or done occurs.
- 256 back-to-back BUS M-cycles -> mcycle_cnt wraps to 0x00 on the 256th done.
- req_kind=7 behaves exactly as KEEP.

Source files
------------

// File: rtl/sm83_adr_seq.sv
// SM83 address-unit M-cycle sequencer: walks T1..T4 per accepted request and
// drives latch, incrementer, memory strobe and write-back controls.
module sm83_adr_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_kind,
    input  logic [1:0] req_dir,
    input  logic       mem_wait,
    output logic       ctl_al_we,
    output logic       ctl_al_hi_ff,
    output logic       ctl_inc_dec,
    output logic       ctl_inc_cy,
    output logic       ctl_inc_oe,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       wb_we,
    output logic       done,
    output logic       busy,
    output logic [7:0] mcycle_cnt
);

    localparam logic [2:0] KIND_BUS      = 3'd0;
    localparam logic [2:0] KIND_INC      = 3'd1;
    localparam logic [2:0] KIND_DEC      = 3'd2;
    localparam logic [2:0] KIND_HIFF     = 3'd3;
    localparam logic [2:0] KIND_KEEP_INC = 3'd4;
    localparam logic [2:0] KIND_KEEP     = 3'd5;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_READ  = 2'b01;
    localparam logic [1:0] DIR_WRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] kind_reg, kind_next;
    logic [1:0] dir_reg, dir_next;
    logic [7:0] cnt_reg, cnt_next;

    logic accept;
    logic dir_mem;
    logic kind_latch_t1;
    logic kind_step;

    // Reserved encodings are folded at latch time so the output decode only
    // ever sees the six legal kinds and three legal directions.
    function automatic logic [2:0] norm_kind(input logic [2:0] k);
        return (k > KIND_KEEP) ? KIND_KEEP : k;
    endfunction

    function automatic logic [1:0] norm_dir(input logic [1:0] d);
        return (d == 2'b11) ? DIR_NONE : d;
    endfunction

    assign req_ready = (state_reg == ST_IDLE) || (state_reg == ST_T4);
    assign accept    = req_valid && req_ready;
    assign dir_mem   = (dir_reg == DIR_READ) || (dir_reg == DIR_WRITE);

    assign kind_latch_t1 = (kind_reg == KIND_BUS) || (kind_reg == KIND_INC) ||
                           (kind_reg == KIND_DEC) || (kind_reg == KIND_HIFF);
    assign kind_step     = (kind_reg == KIND_INC) || (kind_reg == KIND_DEC) ||
                           (kind_reg == KIND_KEEP_INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            kind_reg  <= KIND_BUS;
            dir_reg   <= DIR_NONE;
            cnt_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            kind_reg  <= kind_next;
            dir_reg   <= dir_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        dir_next   = dir_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_T1;
            ST_T1:   state_next = ST_T2;
            // Only bus cycles can be stretched; internal cycles ignore mem_wait.
            ST_T2:   state_next = (mem_wait && dir_mem) ? ST_T2 : ST_T3;
            ST_T3:   state_next = ST_T4;
            ST_T4: begin
                cnt_next   = cnt_reg + 8'd1;
                state_next = accept ? ST_T1 : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (accept) begin
            kind_next = norm_kind(req_kind);
            dir_next  = norm_dir(req_dir);
        end
    end

    // Controls depend only on registered state and latched fields, so they
    // hold steady across the whole period for the falling-edge latch.
    always_comb begin
        ctl_al_we    = 1'b0;
        ctl_al_hi_ff = 1'b0;
        ctl_inc_dec  = 1'b0;
        ctl_inc_cy   = 1'b0;
        ctl_inc_oe   = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        wb_we        = 1'b0;
        done         = 1'b0;

        case (state_reg)
            ST_T1: begin
                ctl_al_we    = kind_latch_t1;
                ctl_al_hi_ff = (kind_reg == KIND_HIFF);
                mem_rd       = (dir_reg == DIR_READ);
                mem_wr       = (dir_reg == DIR_WRITE);
            end
            ST_T2: begin
                mem_rd = (dir_reg == DIR_READ);
                mem_wr = (dir_reg == DIR_WRITE);
            end
            ST_T3: begin
                ctl_al_we   = kind_step;
                ctl_inc_oe  = kind_step;
                ctl_inc_cy  = kind_step;
                ctl_inc_dec = (kind_reg == KIND_DEC);
                mem_rd      = (dir_reg == DIR_READ);
                mem_wr      = (dir_reg == DIR_WRITE);
            end
            ST_T4: begin
                wb_we = kind_step;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_reg != ST_IDLE);
    assign mcycle_cnt = cnt_reg;

endmodule

// File: tb/tb_sm83_adr_seq.sv
// Scoreboard bench for sm83_adr_seq: a transaction-level plan is expanded into
// per-cycle expected output vectors, and a monitor compares them each cycle.
module tb_sm83_adr_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_kind;
    logic [1:0] req_dir;
    logic       mem_wait;
    logic       ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe;
    logic       mem_rd, mem_wr, wb_we, done, busy;
    logic [7:0] mcycle_cnt;

    always #5 clk = ~clk;

    sm83_adr_seq dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_dir     (req_dir),
        .mem_wait    (mem_wait),
        .ctl_al_we   (ctl_al_we),
        .ctl_al_hi_ff(ctl_al_hi_ff),
        .ctl_inc_dec (ctl_inc_dec),
        .ctl_inc_cy  (ctl_inc_cy),
        .ctl_inc_oe  (ctl_inc_oe),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .wb_we       (wb_we),
        .done        (done),
        .busy        (busy),
        .mcycle_cnt  (mcycle_cnt)
    );

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       al_we;
        logic       hi_ff;
        logic       inc_dec;
        logic       inc_cy;
        logic       inc_oe;
        logic       rd;
        logic       wr;
        logic       wb;
        logic       done;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        vec_t v;
        int   id;
        int   ph;
    } exp_t;

    typedef struct {
        logic [2:0] k;
        logic [1:0] d;
        int         w;
        int         gap;
        bit         rst;
    } tx_t;

    exp_t sbq[$];
    tx_t  plan[$];
    int   checks = 0;
    int   errors = 0;
    bit   running = 1'b0;
    logic [7:0] mcnt = 8'h00;
    int   txid = -1;

    // Expected outputs for one clock of a request, phase 0=idle,1..4=T1..T4.
    function automatic vec_t model(input int ph, input logic [2:0] k,
                                   input logic [1:0] d, input logic [7:0] cnt);
        vec_t v;
        int   kk;
        bit   step, bus_ph;
        v      = '0;
        kk     = (k > 3'd5) ? 5 : int'(k);
        step   = (kk == 1) || (kk == 2) || (kk == 4);
        bus_ph = (ph >= 1) && (ph <= 3);
        v.cnt   = cnt;
        v.busy  = (ph != 0);
        v.ready = (ph == 0) || (ph == 4);
        v.rd    = bus_ph && (d == 2'b01);
        v.wr    = bus_ph && (d == 2'b10);
        if (ph == 1) begin
            v.al_we = (kk <= 3);
            v.hi_ff = (kk == 3);
        end
        if (ph == 3) begin
            v.al_we   = step;
            v.inc_oe  = step;
            v.inc_cy  = step;
            v.inc_dec = (kk == 2);
        end
        if (ph == 4) begin
            v.wb   = step;
            v.done = 1'b1;
        end
        return v;
    endfunction

    task automatic emit(input int ph, input logic [2:0] k, input logic [1:0] d,
                        input logic v, input logic [2:0] nk, input logic [1:0] nd,
                        input logic w, input logic r);
        exp_t e;
        e.v  = model(ph, k, d, mcnt);
        e.id = txid;
        e.ph = ph;
        sbq.push_back(e);
        running   = 1'b1;
        req_valid = v;
        req_kind  = nk;
        req_dir   = nd;
        mem_wait  = w;
        reset     = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] k, input logic [1:0] d,
                                input int w, input int gap, input bit rst);
        tx_t t;
        t.k = k; t.d = d; t.w = w; t.gap = gap; t.rst = rst;
        if (rst && t.w < 2) t.w = 2;
        if (plan.size() == 0 || plan[plan.size()-1].rst) begin
            if (t.gap < 1) t.gap = 1;
        end
        plan.push_back(t);
    endfunction

    always @(negedge clk) begin
        if (running) begin
            vec_t act;
            exp_t e;
            act = {req_ready, busy, ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy,
                   ctl_inc_oe, mem_rd, mem_wr, wb_we, done, mcycle_cnt};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underrun: no expected vector, got %b", act);
            end else begin
                e = sbq.pop_front();
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL tx%0d ph%0d rdy/bsy/we/hf/dec/cy/oe/rd/wr/wb/dn/cnt got %b_%h required %b_%h",
                             e.id, e.ph, act[18:8], act[7:0], e.v[18:8], e.v[7:0]);
                end
            end
        end
    end

    initial begin
        // Directed cases from the test plan, then BUS wrap run, then random.
        add(3'd1, 2'b01, 0, 1, 0);              // INC read
        add(3'd2, 2'b10, 2, 2, 0);              // DEC write, 2 waits
        add(3'd3, 2'b01, 0, 1, 0);              // HIFF read
        add(3'd4, 2'b00, 0, 0, 0);              // KEEP_INC none back-to-back
        add(3'd5, 2'b00, 0, 2, 0);              // KEEP none, mem_wait ignored
        add(3'd1, 2'b10, 3, 1, 1);              // reset in second stalled T2
        add(3'd7, 2'b01, 1, 1, 0);              // kind 7 acts as KEEP
        add(3'd7, 2'b00, 0, 0, 0);
        add(3'd6, 2'b11, 2, 0, 0);
        add(3'd0, 2'b10, 2, 1, 1);              // clear counter before wrap run
        for (int i = 0; i < 256; i++)
            add(3'd0, 2'($urandom_range(0, 3)), 0, (i == 0) ? 1 : 0, 0);
        add(3'd2, 2'b01, 1, 1, 0);
        for (int i = 0; i < 300; i++)
            add(3'($urandom), 2'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2), ($urandom_range(0, 19) == 0));

        reset = 1'b1; req_valid = 1'b0; req_kind = 3'd0; req_dir = 2'd0; mem_wait = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < plan.size(); i++) begin
            tx_t        t;
            bit         chain, hold, memc;
            logic [2:0] nk;
            logic [1:0] nd;
            int         nt2;
            bit         aborted;
            t = plan[i];
            if (i == 0 || t.gap > 0) begin
                for (int g = 0; g < t.gap; g++)
                    emit(0, 3'd0, 2'd0, (g == t.gap - 1), t.k, t.d, 1'($urandom), 1'b0);
            end
            txid  = i;
            chain = (i + 1 < plan.size()) && (plan[i+1].gap == 0) && !t.rst;
            hold  = chain && ($urandom_range(0, 1) == 1);
            nk    = chain ? plan[i+1].k : 3'($urandom);
            nd    = chain ? plan[i+1].d : 2'($urandom);
            memc  = (t.d == 2'b01) || (t.d == 2'b10);
            nt2   = memc ? t.w + 1 : 1;
            // Without a chained request, valid may flicker in T1..T3: never accepted.
            emit(1, t.k, t.d, chain ? hold : 1'($urandom), nk, nd, 1'($urandom), 1'b0);
            aborted = 1'b0;
            for (int j = 0; j < nt2; j++) begin
                logic wv;
                wv = memc ? (j < t.w) : 1'b1;
                if (t.rst && j == 1) begin
                    emit(2, t.k, t.d, 1'b0, nk, nd, wv, 1'b1);
                    mcnt    = 8'h00;
                    aborted = 1'b1;
                    break;
                end
                emit(2, t.k, t.d, chain ? hold : 1'($urandom), nk, nd, wv, 1'b0);
            end
            if (!aborted) begin
                emit(3, t.k, t.d, chain ? hold : 1'($urandom), nk, nd, 1'($urandom), 1'b0);
                emit(4, t.k, t.d, chain, nk, nd, 1'($urandom), 1'b0);
                mcnt = mcnt + 8'd1;
            end
        end
        txid = -1;
        emit(0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
        emit(0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        running = 1'b0;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending vectors, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
